// File: rtl/cdc_toggle_rx_fifo.sv
`timescale 1ns/1ps
// cdc_toggle_rx_fifo
// Destination side of a 2-phase toggle handshake. The request toggle is
// synchronised, each new toggle level captures the source's held word into a
// small FIFO, and the accepted level is returned as the ack toggle.
// While the FIFO is full, a pending event is held and its ack is withheld.
// Optional statistics counters are enabled by defining CDC_RX_STATS_EN.
module cdc_toggle_rx_fifo #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEPTH       = 4,
    parameter int CNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_tgl_async,
    input  logic [DATA_W-1:0]        data_async,
    output logic                     ack_tgl,
    output logic [DATA_W-1:0]        data_out,
    output logic                     valid_out,
    input  logic                     ready_in,
    output logic [$clog2(DEPTH):0]   level
`ifdef CDC_RX_STATS_EN
    ,
    output logic [CNT_W-1:0]         xfer_cnt,
    output logic [CNT_W-1:0]         stall_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    if (DATA_W < 1 || SYNC_STAGES < 2 || DEPTH < 2 ||
        (DEPTH & (DEPTH - 1)) != 0 || CNT_W < 1) begin : g_bad_params
        $error("cdc_toggle_rx_fifo: illegal parameter set");
    end

    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   req_q;
    logic [DATA_W-1:0]      mem [DEPTH];
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;

    logic sync_out;
    logic ev;
    logic empty;
    logic full;
    logic wr_en;
    logic pop;

    assign sync_out  = sync_p0[SYNC_STAGES-1];
    assign ev        = sync_out != req_q;
    assign empty     = wr_ptr == rd_ptr;
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // A full FIFO never takes a write, even if the head is popped on the same edge.
    assign wr_en     = ev && !full;
    assign valid_out = !empty;
    assign pop       = valid_out && ready_in;
    assign ack_tgl   = req_q;
    assign data_out  = mem[rd_ptr[AW-1:0]];
    // Pointer difference wraps modulo 2*DEPTH, so it is always 0..DEPTH.
    assign level     = wr_ptr - rd_ptr;

    // Synchroniser chain for the asynchronous request toggle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= '0;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], req_tgl_async};
        end
    end

    // Accept a new toggle level and capture the held source word into the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q  <= 1'b0;
            wr_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            req_q                <= sync_out;
            wr_ptr               <= wr_ptr + PW'(1);
            mem[wr_ptr[AW-1:0]]  <= data_async;
        end
    end

    // Advance the read pointer when the consumer takes the head word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
        end else if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
        end
    end

`ifdef CDC_RX_STATS_EN
    // Count accepted words (wrapping) and full-stall cycles (saturating).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (wr_en) begin
                xfer_cnt <= xfer_cnt + CNT_W'(1);
            end
            if (ev && full && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule
